// File: rtl/elevator_display_pkg.sv
// elevator_display_pkg: symbol codes, segment patterns and motion encoding for the status display
package elevator_display_pkg;
    localparam logic [3:0] SYM_1 = 4'h1, SYM_2 = 4'h2, SYM_3 = 4'h3, SYM_4 = 4'h4;
    localparam logic [3:0] SYM_S = 4'h5, SYM_B = 4'h8, SYM_A = 4'hA, SYM_C = 4'hC;
    localparam logic [3:0] SYM_P = 4'hD, SYM_DASH = 4'hE, SYM_BLANK = 4'hF;
    localparam logic [7:0] SEG_1 = 8'h9F, SEG_2 = 8'h25, SEG_3 = 8'h0D, SEG_4 = 8'h99;
    localparam logic [7:0] SEG_S = 8'h49, SEG_B = 8'hC1, SEG_A = 8'h11, SEG_C = 8'h63;
    localparam logic [7:0] SEG_P = 8'h31, SEG_DASH = 8'hFD, SEG_BLANK = 8'hFF;
    typedef enum logic [1:0] {ACC_IDLE = 2'd0, ACC_UP = 2'd1, ACC_DOWN = 2'd2, ACC_HOLD = 2'd3} accion_t;
endpackage

// File: rtl/elevator_status_display_if.sv
// elevator_status_display_if: controller state in, multiplexed display and square waves out
interface elevator_status_display_if;
    logic [1:0] piso;
    logic [1:0] accion;
    logic       puertas;
    logic [7:0] display;
    logic [3:0] anodes;
    logic       clk_1hz;
    logic       clk_2hz;
    modport master(output piso, accion, puertas, input display, anodes, clk_1hz, clk_2hz);
    modport slave(input piso, accion, puertas, output display, anodes, clk_1hz, clk_2hz);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: registered symbol-code to active-low segment decoder, unknown codes blank
module seg7_decode
    import elevator_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code,
    output logic [7:0] seg
);
    logic [7:0] seg_d;
    always_comb begin
        seg_d = SEG_BLANK;
        case (code)
            SYM_1:    seg_d = SEG_1;
            SYM_2:    seg_d = SEG_2;
            SYM_3:    seg_d = SEG_3;
            SYM_4:    seg_d = SEG_4;
            SYM_S:    seg_d = SEG_S;
            SYM_B:    seg_d = SEG_B;
            SYM_A:    seg_d = SEG_A;
            SYM_C:    seg_d = SEG_C;
            SYM_P:    seg_d = SEG_P;
            SYM_DASH: seg_d = SEG_DASH;
            default:  seg_d = SEG_BLANK;
        endcase
    end
    always_ff @(posedge clk)
        seg <= rst ? SEG_BLANK : seg_d;
endmodule

// File: rtl/elevator_status_display.sv
// elevator_status_display: 4-digit status display with refresh scan and 1/2 Hz waves; DOOR_BLINK_EN blinks the open-door 'A' with clk_2hz
module elevator_status_display
    import elevator_display_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input logic clk,
    input logic rst,
    elevator_status_display_if.slave bus
);
    localparam int REF_DIV = CLK_HZ / REFRESH_HZ;
    localparam int Q       = CLK_HZ / 4;
    localparam int CW      = $clog2(CLK_HZ);
    localparam int RW      = $clog2(REF_DIV);
    logic [CW-1:0] cnt;
    logic [RW-1:0] ref_cnt;
    logic          ref_tick, q_hit, h_hit, clk_1hz, clk_2hz;
    logic [1:0]    idx;
    logic [3:0]    sym_d [4];
    logic [3:0]    sym [4];
    logic [7:0]    seg [4];
    assign ref_tick = ref_cnt == RW'(REF_DIV - 1);
    // one base counter per second; quarter-second marks drive both square waves
    assign h_hit = cnt == CW'(2 * Q - 1) || cnt == CW'(CLK_HZ - 1);
    assign q_hit = h_hit || cnt == CW'(Q - 1) || cnt == CW'(3 * Q - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            ref_cnt <= '0;
            clk_1hz <= 1'b0;
            clk_2hz <= 1'b0;
            idx     <= 2'd0;
        end else begin
            cnt     <= cnt == CW'(CLK_HZ - 1) ? '0 : cnt + CW'(1);
            ref_cnt <= ref_tick ? '0 : ref_cnt + RW'(1);
            clk_1hz <= clk_1hz ^ h_hit;
            clk_2hz <= clk_2hz ^ q_hit;
            idx     <= idx + {1'b0, ref_tick};
        end
    end
    always_comb begin
        sym_d[0] = {2'b00, bus.piso} + 4'd1;
        sym_d[1] = SYM_P;
`ifdef DOOR_BLINK_EN
        sym_d[2] = bus.puertas ? (clk_2hz ? SYM_A : SYM_BLANK) : SYM_C;
`else
        sym_d[2] = bus.puertas ? SYM_A : SYM_C;
`endif
        sym_d[3] = bus.accion == ACC_UP ? SYM_S : bus.accion == ACC_DOWN ? SYM_B : SYM_DASH;
    end
    always_ff @(posedge clk)
        for (int j = 0; j < 4; j++)
            sym[j] <= rst ? SYM_BLANK : sym_d[j];
    for (genvar i = 0; i < 4; i++) begin : g_dec
        seg7_decode u_dec (.clk(clk), .rst(rst), .code(sym[i]), .seg(seg[i]));
    end
    always_ff @(posedge clk) begin
        bus.display <= rst ? SEG_BLANK : seg[idx];
        bus.anodes  <= rst ? 4'b1111 : ~(4'b0001 << idx);
    end
    assign bus.clk_1hz = clk_1hz;
    assign bus.clk_2hz = clk_2hz;
endmodule

// File: tb/tb_elevator_status_display.sv
// tb_elevator_status_display: directed checks of scan, symbols, latency, square waves and reset (CLK_HZ=16, REFRESH_HZ=4)
module tb_elevator_status_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    elevator_status_display_if bus();
    elevator_status_display #(.CLK_HZ(16), .REFRESH_HZ(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic settle();
        repeat (3) tick();
    endtask
    task automatic show(input string tag, input logic [3:0] pat, input logic [7:0] exp);
        for (int n = 0; n < 20 && bus.anodes !== pat; n++) tick();
        chk({tag, "_an"}, {4'h0, bus.anodes}, {4'h0, pat});
        chk(tag, bus.display, exp);
    endtask
    task automatic wait_phase(input int ph);
        for (int n = 0; n < 16 && cyc % 16 != ph; n++) tick();
    endtask
    initial begin
        bus.piso = 2'd2;
        bus.accion = 2'd0;
        bus.puertas = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_an", {4'h0, bus.anodes}, 8'h0F);
        chk("rst_disp", bus.display, 8'hFF);
        chk("rst_1hz", {7'd0, bus.clk_1hz}, 8'd0);
        chk("rst_2hz", {7'd0, bus.clk_2hz}, 8'd0);
        rst = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("scan_an", {4'h0, bus.anodes}, {4'h0, ~(4'b0001 << (((k - 1) / 4) % 4))});
            chk("wave_2hz", {7'd0, bus.clk_2hz}, 8'((k / 4) % 2));
            chk("wave_1hz", {7'd0, bus.clk_1hz}, 8'((k / 8) % 2));
        end
        show("p2_d0", 4'b1110, 8'h0D);
        show("p2_d1", 4'b1101, 8'h31);
        show("p2_d2", 4'b1011, 8'h63);
        show("p2_d3", 4'b0111, 8'hFD);
        bus.piso = 2'd0;
        bus.accion = 2'd1;
        settle();
        show("up_d0", 4'b1110, 8'h9F);
        show("up_d3", 4'b0111, 8'h49);
        bus.accion = 2'd2;
        settle();
        show("down_d3", 4'b0111, 8'hC1);
        bus.puertas = 1'b1;
        settle();
        wait_phase(9);
        for (int n = 0; n < 4; n++) begin
            chk("door_an", {4'h0, bus.anodes}, 8'h0B);
`ifdef DOOR_BLINK_EN
            chk("door_blink", bus.display, ((cyc - 3) / 4) % 2 == 1 ? 8'h11 : 8'hFF);
`else
            chk("door_open", bus.display, 8'h11);
`endif
            tick();
        end
        bus.puertas = 1'b0;
        bus.piso = 2'd3;
        settle();
        wait_phase(1);
        chk("lat_an", {4'h0, bus.anodes}, 8'h0E);
        chk("lat_before", bus.display, 8'h99);
        bus.piso = 2'd1;
        tick();
        tick();
        chk("lat_2cyc", bus.display, 8'h99);
        tick();
        chk("lat_3cyc", bus.display, 8'h25);
        bus.accion = 2'd3;
        settle();
        show("hold_d3", 4'b0111, 8'hFD);
        wait_phase(13);
        chk("mid_an", {4'h0, bus.anodes}, 8'h07);
        chk("mid_1hz", {7'd0, bus.clk_1hz}, 8'd1);
        chk("mid_2hz", {7'd0, bus.clk_2hz}, 8'd1);
        rst = 1'b1;
        tick();
        chk("mrst_an", {4'h0, bus.anodes}, 8'h0F);
        chk("mrst_disp", bus.display, 8'hFF);
        chk("mrst_1hz", {7'd0, bus.clk_1hz}, 8'd0);
        chk("mrst_2hz", {7'd0, bus.clk_2hz}, 8'd0);
        rst = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("restart_an", {4'h0, bus.anodes}, k <= 4 ? 8'h0E : 8'h0D);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
